// File: rtl/d_mem_arb.sv
// d_mem_arb: shares the single data_mem port between the CPU datapath and a
// host/debug requester. The host steals one CPU cycle per access (cpu_stall),
// and a wait counter bounds how long the host can be starved by a CPU that
// hits memory every cycle.
module d_mem_arb #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned MAX_WAIT = 4,
    parameter int unsigned WAIT_W   = 3
) (
    input  logic             clk_i,
    input  logic             rst_ni,

    // CPU side
    input  logic             cpu_req_i,
    input  logic             cpu_we_i,
    input  logic [WIDTH-1:0] cpu_addr_i,
    input  logic [WIDTH-1:0] cpu_wdata_i,
    output logic             cpu_stall_o,

    // Host side
    input  logic             host_req_i,
    input  logic             host_we_i,
    input  logic [WIDTH-1:0] host_addr_i,
    input  logic [WIDTH-1:0] host_wdata_i,
    output logic             host_gnt_o,
    output logic [WIDTH-1:0] host_rdata_o,

    // data_mem side
    output logic             mem_en_o,
    output logic [WIDTH-1:0] mem_addr_o,
    output logic [WIDTH-1:0] mem_d_in_o,
    input  logic [WIDTH-1:0] mem_d_out_i
);

    typedef enum logic [0:0] {
        StCpu  = 1'b0,
        StHost = 1'b1
    } state_e;

    localparam logic [WAIT_W-1:0] MaxWait = WAIT_W'(MAX_WAIT);

    state_e             state_q, state_d;
    logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic [WIDTH-1:0]   host_rdata_q, host_rdata_d;

    // The host slot only performs an access if the request is still present;
    // a dropped request turns the slot into a dead cycle with no side effects.
    logic host_active;
    logic wait_expired;
    logic wait_sat;

    assign host_active  = (state_q == StHost) && host_req_i;
    assign wait_expired = (wait_cnt_q >= MaxWait);
    assign wait_sat     = (wait_cnt_q == {WAIT_W{1'b1}});

    // State, wait counter and captured host read data.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= StCpu;
            wait_cnt_q   <= '0;
            host_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            wait_cnt_q   <= wait_cnt_d;
            host_rdata_q <= host_rdata_d;
        end
    end

    // Next-state logic: host enters when CPU is idle or the wait budget is spent.
    always_comb begin
        state_d      = state_q;
        wait_cnt_d   = wait_cnt_q;
        host_rdata_d = host_rdata_q;

        unique case (state_q)
            StCpu: begin
                if (!host_req_i) begin
                    wait_cnt_d = '0;
                end else if (!cpu_req_i || wait_expired) begin
                    state_d    = StHost;
                    wait_cnt_d = '0;
                end else if (!wait_sat) begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            StHost: begin
                // Host owns the port for exactly one cycle, so the CPU always
                // gets at least one cycle between successive grants.
                state_d    = StCpu;
                wait_cnt_d = '0;
                if (host_req_i) begin
                    // Captured on write grants too: returns the pre-write data.
                    host_rdata_d = mem_d_out_i;
                end
            end
            default: begin
                state_d    = StCpu;
                wait_cnt_d = '0;
            end
        endcase
    end

    // Port mux and handshake outputs; stall depends only on state and host_req.
    always_comb begin
        mem_addr_o  = cpu_addr_i;
        mem_d_in_o  = cpu_wdata_i;
        mem_en_o    = cpu_we_i;
        cpu_stall_o = 1'b0;
        host_gnt_o  = 1'b0;

        if (state_q == StHost) begin
            mem_addr_o  = host_addr_i;
            mem_d_in_o  = host_wdata_i;
            mem_en_o    = host_active && host_we_i;
            cpu_stall_o = host_active;
            host_gnt_o  = host_active;
        end
    end

    assign host_rdata_o = host_rdata_q;

endmodule

// File: tb/tb_d_mem_arb.sv
// Bench for d_mem_arb: two instances (MAX_WAIT=4 and MAX_WAIT=0) share one
// stimulus stream; a slot-level model predicts every output each cycle, and
// directed steps pin specific hand-computed values.
module tb_d_mem_arb;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cpu_req = 1'b0, cpu_we = 1'b0;
    logic [7:0] cpu_addr = 8'h00, cpu_wdata = 8'h00;
    logic       host_req = 1'b0, host_we = 1'b0;
    logic [7:0] host_addr = 8'h00, host_wdata = 8'h00;

    logic       stall_w  [2];
    logic       gnt_w    [2];
    logic       mem_en_w [2];
    logic [7:0] rdata_w  [2];
    logic [7:0] addr_w   [2];
    logic [7:0] din_w    [2];
    logic [7:0] dout_w   [2];

    logic [7:0] mem [2][256];

    int n_checks = 0;
    int n_errors = 0;
    bit run = 1'b0;

    always #5 clk = ~clk;

    d_mem_arb #(.WIDTH(8), .MAX_WAIT(4), .WAIT_W(3)) u_a (
        .clk_i(clk), .rst_ni(rst_n),
        .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr),
        .cpu_wdata_i(cpu_wdata), .cpu_stall_o(stall_w[0]),
        .host_req_i(host_req), .host_we_i(host_we), .host_addr_i(host_addr),
        .host_wdata_i(host_wdata), .host_gnt_o(gnt_w[0]), .host_rdata_o(rdata_w[0]),
        .mem_en_o(mem_en_w[0]), .mem_addr_o(addr_w[0]), .mem_d_in_o(din_w[0]),
        .mem_d_out_i(dout_w[0])
    );

    d_mem_arb #(.WIDTH(8), .MAX_WAIT(0), .WAIT_W(1)) u_b (
        .clk_i(clk), .rst_ni(rst_n),
        .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr),
        .cpu_wdata_i(cpu_wdata), .cpu_stall_o(stall_w[1]),
        .host_req_i(host_req), .host_we_i(host_we), .host_addr_i(host_addr),
        .host_wdata_i(host_wdata), .host_gnt_o(gnt_w[1]), .host_rdata_o(rdata_w[1]),
        .mem_en_o(mem_en_w[1]), .mem_addr_o(addr_w[1]), .mem_d_in_o(din_w[1]),
        .mem_d_out_i(dout_w[1])
    );

    // Combinational-read data memory, one per instance.
    assign dout_w[0] = mem[0][addr_w[0]];
    assign dout_w[1] = mem[1][addr_w[1]];

    initial begin
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 256; i++)
                mem[k][i] <= 8'h00;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model: m_host says whether the current cycle is a host slot; m_conf counts
    // consecutive cycles the host has been refused because the CPU was busy.
    int unsigned maxw [2] = '{4, 0};
    bit          m_host  [2];
    int          m_conf  [2];
    logic [7:0]  m_rdata [2];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) begin
                m_host[k]  = 1'b0;
                m_conf[k]  = 0;
                m_rdata[k] = 8'h00;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin : upd
                bit go;
                if (m_host[k] && host_req) m_rdata[k] = mem[k][host_addr];
                if (mem_en_w[k]) mem[k][addr_w[k]] <= din_w[k];
                go = !m_host[k] && host_req && (!cpu_req || m_conf[k] >= int'(maxw[k]));
                if (!m_host[k] && host_req && cpu_req && !go) m_conf[k] = m_conf[k] + 1;
                else m_conf[k] = 0;
                m_host[k] = go;
            end
        end
    end

    // Compare every output of both instances against the model mid-cycle.
    always @(negedge clk) begin
        if (run && rst_n) begin
            for (int k = 0; k < 2; k++) begin
                string p;
                bit    act;
                p   = (k == 0) ? "A." : "B.";
                act = m_host[k] && host_req;
                chk({p, "stall"}, stall_w[k], act);
                chk({p, "gnt"}, gnt_w[k], act);
                chk({p, "mem_en"}, mem_en_w[k], m_host[k] ? (act && host_we) : cpu_we);
                chk({p, "mem_addr"}, addr_w[k], m_host[k] ? host_addr : cpu_addr);
                chk({p, "mem_d_in"}, din_w[k], m_host[k] ? host_wdata : cpu_wdata);
                chk({p, "host_rdata"}, rdata_w[k], m_rdata[k]);
            end
        end
    end

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int ga[$];
        int gb[$];
        bit sa[14];
        int viol;

        // Reset
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        run = 1'b1;
        #1;
        chk("rst_rdata", rdata_w[0], 8'h00);
        chk("rst_stall", stall_w[0], 1'b0);
        chk("rst_gnt", gnt_w[0], 1'b0);

        // CPU passthrough write 0x03 <- 0x7E
        next();
        cpu_req = 1; cpu_we = 1; cpu_addr = 8'h03; cpu_wdata = 8'h7E;
        #1;
        chk("pass_en", mem_en_w[0], 1'b1);
        chk("pass_addr", addr_w[0], 8'h03);
        chk("pass_din", din_w[0], 8'h7E);
        chk("pass_stall", stall_w[0], 1'b0);
        chk("pass_en_b", mem_en_w[1], 1'b1);

        // Idle host write 0x10 <- 0xA5: grant in the 2nd cycle
        next();
        cpu_req = 0; cpu_we = 0;
        host_req = 1; host_we = 1; host_addr = 8'h10; host_wdata = 8'hA5;
        #1;
        chk("hw_gnt_c1", gnt_w[0], 1'b0);
        next(); #1;
        chk("hw_gnt", gnt_w[0], 1'b1);
        chk("hw_en", mem_en_w[0], 1'b1);
        chk("hw_addr", addr_w[0], 8'h10);
        chk("hw_din", din_w[0], 8'hA5);
        chk("hw_stall", stall_w[0], 1'b1);
        chk("hw_gnt_b", gnt_w[1], 1'b1);
        next();
        host_req = 0; host_we = 0;
        #1;
        chk("hw_gnt_after", gnt_w[0], 1'b0);
        chk("hw_rdata_prewrite", rdata_w[0], 8'h00);

        // Idle host read 0x10
        next();
        host_req = 1; host_addr = 8'h10;
        next(); #1;
        chk("hr_gnt", gnt_w[0], 1'b1);
        next();
        host_req = 0;
        #1;
        chk("hr_rdata", rdata_w[0], 8'hA5);
        chk("hr_rdata_b", rdata_w[1], 8'hA5);

        // Starvation bound with continuous CPU reads and host held
        next();
        cpu_req = 1; cpu_we = 0; cpu_addr = 8'h10;
        host_req = 1; host_we = 0; host_addr = 8'h03;
        for (int i = 0; i < 14; i++) begin
            if (i > 0) next();
            #1;
            if (gnt_w[0]) ga.push_back(i);
            if (gnt_w[1]) gb.push_back(i);
            sa[i] = stall_w[0];
        end
        chk("starve_cnt_a", ga.size(), 2);
        if (ga.size() >= 2) begin
            chk("starve_first_a", ga[0], 5);
            chk("starve_second_a", ga[1], 11);
        end
        chk("starve_stall4", sa[4], 1'b0);
        chk("starve_stall5", sa[5], 1'b1);
        chk("starve_rdata", rdata_w[0], 8'h7E);
        chk("mw0_cnt", gb.size(), 7);
        if (gb.size() >= 1) chk("mw0_first", gb[0], 1);
        viol = 0;
        for (int j = 1; j < gb.size(); j++)
            if (gb[j] - gb[j-1] < 2) viol++;
        chk("mw0_gap", viol, 0);

        // Abort: host_req drops in the host slot
        next();
        host_req = 0; cpu_req = 0; cpu_we = 0;
        next();
        next();
        host_req = 1; host_we = 1; host_addr = 8'h40; host_wdata = 8'h99;
        next();
        host_req = 0;
        #1;
        chk("ab_gnt", gnt_w[0], 1'b0);
        chk("ab_en", mem_en_w[0], 1'b0);
        chk("ab_stall", stall_w[0], 1'b0);
        chk("ab_addr", addr_w[0], 8'h40);
        chk("ab_rdata", rdata_w[0], 8'h7E);
        next();
        cpu_req = 1; cpu_we = 1; cpu_addr = 8'h41; cpu_wdata = 8'h22;
        #1;
        chk("ab_cpu_en", mem_en_w[0], 1'b1);
        chk("ab_cpu_addr", addr_w[0], 8'h41);
        chk("ab_nowrite", mem[0][8'h40], 8'h00);

        // Reset in the middle of a host write slot
        next();
        cpu_req = 0; cpu_we = 0;
        host_req = 1; host_we = 1; host_addr = 8'h20; host_wdata = 8'h55;
        next(); #1;
        chk("rs_gnt_pre", gnt_w[0], 1'b1);
        #1 rst_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("rs_en", mem_en_w[k], 1'b0);
            chk("rs_gnt", gnt_w[k], 1'b0);
            chk("rs_stall", stall_w[k], 1'b0);
            chk("rs_rdata", rdata_w[k], 8'h00);
        end
        next();
        rst_n = 1'b1;
        host_req = 0; host_we = 0;
        cpu_req = 1; cpu_we = 1; cpu_addr = 8'h05; cpu_wdata = 8'h11;
        #1;
        chk("rs_nowrite", mem[0][8'h20], 8'h00);
        chk("rs_cpu_en", mem_en_w[0], 1'b1);
        chk("rs_cpu_addr", addr_w[0], 8'h05);
        chk("rs_cpu_din", din_w[0], 8'h11);

        next();
        next();
        run = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/d_mem_arb.md
Name: d_mem_arb

Overview:
- Arbitrates the single data_mem port between the CPU datapath and a host/debug requester (loader, monitor).
- Sits between the CPU's data-memory address/data/enable nets and data_mem.
- Host accesses steal one CPU cycle each, signalled by cpu_stall (the PC and accumulator must hold while it is high).
- A wait counter bounds host starvation when the CPU accesses memory continuously.

Parameters:
- WIDTH, 8, data and address width.
- MAX_WAIT, 4, consecutive CPU/host conflict cycles tolerated before the host is forced in; 0 = host always wins next cycle.
- WAIT_W, 3, wait counter width; must hold MAX_WAIT.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous active-low reset (0 = reset).
- cpu_req  input  1  CPU uses data_mem this cycle (read or write).
- cpu_we  input  1  CPU write enable.
- cpu_addr  input  WIDTH  CPU address (direct or register-indirect, already muxed).
- cpu_wdata  input  WIDTH  CPU write data (accumulator).
- cpu_stall  output  1  CPU must not advance or commit this cycle.
- host_req  input  1  host transaction pending; held with addr/we/wdata stable until host_gnt.
- host_we  input  1  host write enable.
- host_addr  input  WIDTH  host address.
- host_wdata  input  WIDTH  host write data.
- host_gnt  output  1  one-cycle pulse: host access performed this cycle.
- host_rdata  output  WIDTH  registered read data from the last granted host access.
- mem_en  output  1  data_mem write enable.
- mem_addr  output  WIDTH  data_mem address.
- mem_d_in  output  WIDTH  data_mem write data.
- mem_d_out  input  WIDTH  data_mem combinational read data.

Behaviour:
- FSM states: CPU (reset state), HOST. Registers: state, wait_cnt, host_rdata.
- Reset (rst=0, async): state=CPU, wait_cnt=0, host_rdata=0. This forces cpu_stall=0, host_gnt=0 and mem_en=cpu_we.
- CPU state: mem_addr=cpu_addr, mem_d_in=cpu_wdata, mem_en=cpu_we, cpu_stall=0, host_gnt=0.
- Transitions from CPU:
  - host_req & !cpu_req → HOST; wait_cnt←0.
  - host_req & cpu_req & wait_cnt>=MAX_WAIT → HOST; wait_cnt←0.
  - host_req & cpu_req & wait_cnt<MAX_WAIT → stay in CPU; wait_cnt←wait_cnt+1 (saturating).
  - !host_req → stay in CPU; wait_cnt←0.
- HOST state, with host_req=1:
  - mem_addr=host_addr, mem_d_in=host_wdata, mem_en=host_we.
  - host_gnt=1, cpu_stall=1.
  - host_rdata←mem_d_out at the clock edge ending the cycle. It is valid from the next cycle and holds until the next grant; it is updated on write grants too, capturing the pre-write data.
  - Next state: CPU unconditionally. Host ownership is exactly one cycle.
- HOST state, with host_req=0 (host aborted): mem_en=0, host_gnt=0, cpu_stall=0; mux still selects host; host_rdata unchanged; next state CPU.
- Grant latency:
  - Idle CPU: the host is granted in the 2nd cycle after host_req rises.
  - Continuous CPU traffic: grant after MAX_WAIT+1 CPU-state cycles, then the HOST cycle.
- Back-to-back host requests always separate grants by at least one CPU-state cycle, so the CPU progresses at least once per two cycles.
- cpu_stall is combinational from state and host_req only. It never depends on cpu_req, so there is no loop through CPU decode.
- A CPU access attempted during a stall cycle is not performed. The CPU re-presents it next cycle because PC/ACC were held.
- Reset mid-HOST: the grant is dropped immediately (async) and no write occurs after rst falls.

Test Plan:
- Reset: pulse rst=0 while in HOST with host_we=1 → mem_en, host_gnt, cpu_stall drop to 0 within the same cycle; host_rdata=0x00; the next cycle passes CPU signals.
- Idle host write/read: cpu_req=0; host write 0x10←0xA5 → host_gnt in cycle 2, mem_en=1, mem_addr=0x10, mem_d_in=0xA5. Then host read 0x10 → host_rdata=0xA5 the cycle after gnt.
- CPU passthrough: state CPU, cpu_req=1, cpu_we=1, cpu_addr=0x03, cpu_wdata=0x7E → mem_en=1, mem_addr=0x03, mem_d_in=0x7E, cpu_stall=0.
- Starvation bound: MAX_WAIT=4, cpu_req=1 every cycle, host_req held → exactly 5 CPU-state cycles, then one cycle with cpu_stall=1 and host_gnt=1. Repeat with host_req held → grants every 6 cycles.
- Abort: host_req drops in the HOST cycle → host_gnt=0, mem_en=0, cpu_stall=0, host_rdata unchanged, back to CPU.
- MAX_WAIT=0 instance: cpu_req=1 continuously, host_req rises → grant on the next cycle, then at least one CPU cycle between successive grants.
